// File: rtl/amstrad_tape_pulse_player.sv
// Cassette pulse-length player for the CPC tape-in line.
// Byte stream of 16-bit LE records in, tape level out on qualified 4 MHz ticks.
module amstrad_tape_pulse_player #(
  parameter int unsigned MS_TICKS    = 4000,
  parameter bit          PAUSE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_4,
  input  logic       motor,
  input  logic       play,
  input  logic [7:0] stream_data,
  input  logic       stream_valid,
  output logic       stream_ready,
  output logic       tape_level,
  output logic       active,
  output logic       underrun
);

  typedef enum logic [1:0] {
    F_LO,
    F_HI,
    F_PLO,
    F_PHI
  } fetch_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_PULSE,
    T_PAUSE
  } tmr_t;

  localparam logic [27:0] LP_MS = 28'(MS_TICKS);

  fetch_t      r_fst;
  tmr_t        r_tst;
  logic [7:0]  r_lo;
  logic        r_full;
  logic        r_pause;
  logic [15:0] r_val;
  logic        r_rdy;
  logic [27:0] r_rem;
  logic        r_level;
  logic        r_und;

  logic        w_xfer;
  logic        w_qt;
  logic [15:0] w_word;
  logic        w_fill;
  logic        w_take;
  logic        w_full_nxt;
  logic [27:0] w_pticks;

  assign w_qt   = ce_4 & motor & play;
  assign w_xfer = stream_valid & stream_ready;
  assign w_word = {stream_data, r_lo};

  assign w_fill = w_xfer &
                  (((r_fst == F_HI) & (w_word != 16'd0)) |
                   (r_fst == F_PHI));

  // A running record hands over only when its count is spent.
  assign w_take = w_qt & r_full &
                  ((r_tst == T_IDLE) | (r_rem == 28'd0));

  assign w_full_nxt = w_fill | (r_full & ~w_take);

  // A zero-length pause still occupies one tick.
  assign w_pticks = (r_val == 16'd0) ? 28'd0
                  : 28'(r_val) * LP_MS - 28'd1;

  assign stream_ready = r_rdy & play & ~reset;
  assign tape_level   = r_level;
  assign active       = (r_tst != T_IDLE);
  assign underrun     = r_und;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fst   <= F_LO;
      r_lo    <= 8'd0;
      r_full  <= 1'b0;
      r_pause <= 1'b0;
      r_val   <= 16'd0;
      r_rdy   <= 1'b0;
    end else if (!play) begin
      r_fst  <= F_LO;
      r_full <= 1'b0;
      r_rdy  <= 1'b1;
    end else begin
      r_rdy  <= ~w_full_nxt;
      r_full <= w_full_nxt;
      if (w_xfer) begin
        unique case (r_fst)
          F_LO: begin
            r_lo  <= stream_data;
            r_fst <= F_HI;
          end
          F_HI: begin
            if (w_word == 16'd0) begin
              r_fst <= F_PLO;
            end else begin
              r_pause <= 1'b0;
              r_val   <= w_word;
              r_fst   <= F_LO;
            end
          end
          F_PLO: begin
            r_lo  <= stream_data;
            r_fst <= F_PHI;
          end
          F_PHI: begin
            r_pause <= 1'b1;
            r_val   <= w_word;
            r_fst   <= F_LO;
          end
          default: r_fst <= F_LO;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tst   <= T_IDLE;
      r_rem   <= 28'd0;
      r_level <= 1'b0;
      r_und   <= 1'b0;
    end else if (!play) begin
      r_tst <= T_IDLE;
      r_rem <= 28'd0;
      r_und <= 1'b0;
    end else if (w_take) begin
      r_und <= 1'b0;
      if (r_pause) begin
        r_level <= PAUSE_LEVEL;
        r_rem   <= w_pticks;
        r_tst   <= T_PAUSE;
      end else begin
        r_level <= ~r_level;
        r_rem   <= {12'd0, r_val - 16'd1};
        r_tst   <= T_PULSE;
      end
    end else if (w_qt && r_tst != T_IDLE) begin
      if (r_rem != 28'd0) begin
        r_rem <= r_rem - 28'd1;
      end else begin
        r_tst <= T_IDLE;
        r_und <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_amstrad_tape_pulse_player.sv
// Bench for amstrad_tape_pulse_player: per-tick scoreboard of
// {tape_level, active, underrun} against a record-expansion model.
module tb_amstrad_tape_pulse_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_4 = 1'b0;
  logic       motor = 1'b0;
  logic       play = 1'b0;
  logic [7:0] stream_data = 8'h00;
  logic       stream_valid = 1'b0;
  logic       stream_ready;
  logic       tape_level;
  logic       active;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] bq[$];
  logic [2:0] exp_q[$];
  logic       mlev = 1'b0;
  int unsigned cnt = 0;
  bit         drv_acc;

  amstrad_tape_pulse_player #(
    .MS_TICKS(4),
    .PAUSE_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ce_4(ce_4),
    .motor(motor),
    .play(play),
    .stream_data(stream_data),
    .stream_valid(stream_valid),
    .stream_ready(stream_ready),
    .tape_level(tape_level),
    .active(active),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cnt++;
    ce_4 = (cnt % 4 == 0);
  end

  always @(posedge clk) begin
    drv_acc = stream_valid & stream_ready;
    #1;
    if (drv_acc && bq.size() > 0) void'(bq.pop_front());
    stream_valid = (bq.size() > 0);
    stream_data  = stream_valid ? bq[0] : 8'h00;
  end

  task automatic wait_qt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (ce_4 && motor && play && !reset) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic push_pulse(input logic [15:0] n);
    bq.push_back(n[7:0]);
    bq.push_back(n[15:8]);
    mlev = ~mlev;
    repeat (n) exp_q.push_back({mlev, 2'b10});
  endtask

  task automatic push_pause(input logic [15:0] ms);
    int t;
    bq.push_back(8'h00);
    bq.push_back(8'h00);
    bq.push_back(ms[7:0]);
    bq.push_back(ms[15:8]);
    mlev = 1'b0;
    t = (ms == 16'd0) ? 1 : int'(ms) * 4;
    repeat (t) exp_q.push_back({mlev, 2'b10});
  endtask

  task automatic push_end();
    exp_q.push_back({mlev, 2'b01});
  endtask

  task automatic arm();
    repeat (12) @(negedge clk);
    motor = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    checks++;
    if (stream_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0", stream_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({tape_level, active, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL rst_outs got %b want 000", {tape_level, active, underrun});
    end
    @(negedge clk);
    checks++;
    if (stream_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after got %b want 1", stream_ready);
    end
  endtask

  task automatic test_pulses();
    bit ok;
    logic [2:0] e;
    push_pulse(16'd3);
    push_pulse(16'd2);
    push_end();
    arm();
    while (exp_q.size() != 0) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pulses timeout");
        exp_q.delete();
      end else if ({tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL pulses got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
  endtask

  task automatic test_pause();
    bit ok;
    logic [2:0] e;
    push_pulse(16'd2);
    push_pause(16'd2);
    push_end();
    arm();
    while (exp_q.size() != 0) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pause timeout");
        exp_q.delete();
      end else if ({tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL pause got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
  endtask

  task automatic test_motor_freeze();
    bit ok;
    logic [2:0] e;
    logic [2:0] last;
    push_pulse(16'd10);
    push_pulse(16'd5);
    push_end();
    arm();
    last = 3'b000;
    for (int k = 0; k < 4; k++) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      last = e;
      checks++;
      if (!ok || {tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL freeze_pre got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if ({tape_level, active, underrun} !== last) begin
      errors++;
      $display("FAIL freeze_hold got %b want %b", {tape_level, active, underrun}, last);
    end
    checks++;
    if (stream_ready !== 1'b0) begin
      errors++;
      $display("FAIL freeze_prefetch got %b want 0", stream_ready);
    end
    motor = 1'b1;
    while (exp_q.size() != 0) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL freeze timeout");
        exp_q.delete();
      end else if ({tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL freeze got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [2:0] e;
    repeat (4) push_pulse(16'd1);
    push_end();
    arm();
    while (exp_q.size() != 0) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b timeout");
        exp_q.delete();
      end else if ({tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL b2b got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [2:0] e;
    push_pulse(16'd600);
    bq.push_back(8'h07);
    arm();
    for (int k = 0; k < 5; k++) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL rmid_pre got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tape_level, active, underrun, stream_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_reset got %b want 0000", {tape_level, active, underrun, stream_ready});
    end
    exp_q.delete();
    bq.delete();
    mlev = 1'b0;
    motor = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    push_pulse(16'd2);
    push_end();
    arm();
    while (exp_q.size() != 0) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rmid timeout");
        exp_q.delete();
      end else if ({tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL rmid got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
  endtask

  task automatic test_play_flush();
    bit ok;
    logic [2:0] e;
    push_pause(16'd5);
    bq.push_back(8'h07);
    bq.push_back(8'h00);
    arm();
    for (int k = 0; k < 3; k++) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL flush_pre got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    play = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tape_level, active, underrun, stream_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL flush_state got %b want 0000", {tape_level, active, underrun, stream_ready});
    end
    exp_q.delete();
    motor = 1'b0;
    play = 1'b1;
    push_pulse(16'd3);
    push_end();
    arm();
    while (exp_q.size() != 0) begin
      wait_qt(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL flush timeout");
        exp_q.delete();
      end else if ({tape_level, active, underrun} !== e) begin
        errors++;
        $display("FAIL flush got %b want %b", {tape_level, active, underrun}, e);
      end
    end
    motor = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pulses();
    test_pause();
    test_motor_freeze();
    test_back_to_back();
    test_reset_mid();
    test_play_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
